lcd_panel_model: RTL and testbench

- Responder-side model of the HD44780-style character LCD bus driven by the team's LCD controllers.
- Samples LCD_E/LCD_RS/LCD_RW/LCD_DATA and decodes instructions and data transfers.
- Maintains an 80-byte DDRAM, the address counter (AC), display and mode flags, and a busy timer.
- Used as the panel stand-in in system benches and as an on-chip shadow display; exposes a scan port so other blocks can read the displayed characters.

---
 rtl/lcd_panel_model.sv | 327 ++++++++++++++++++++++++++++++++
 tb/tb_lcd_panel_model.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_panel_model.sv
// -----------------------------------------------------------------------------
// lcd_panel_model
//
// Responder-side model of an HD44780-style character LCD. It samples the host
// bus (E/RS/RW/DATA), decodes instructions and data transfers, and keeps the
// 80-byte DDRAM, the address counter, the display/mode flags and a busy timer.
// A scan port lets other logic read the displayed characters independently of
// the host bus.
//
// Ports:
//   CLK        system clock, all state on posedge
//   RESETN     asynchronous reset, active-high
//   LCD_E      enable strobe from host (transfer taken on its falling edge)
//   LCD_RS     0 = instruction/status, 1 = data
//   LCD_RW     0 = write, 1 = read
//   LCD_DATA   host write data
//   DQ_OUT     read-back data to host
//   DQ_OE      high while a read is in progress
//   BUSY       busy flag
//   AC         address counter
//   DISP_ON / CURSOR_ON / BLINK_ON   display control bits D/C/B
//   INC        entry mode I/D bit
//   TWO_LINE   function set N bit
//   OVERRUN    sticky: a transfer was ignored because the panel was busy
//   ADDR_ERR   sticky: set-DDRAM-address with an illegal address
//   SCAN_ADDR  DDRAM index 0..79 for the display scan
//   SCAN_CHAR  DDRAM[SCAN_ADDR], one-cycle registered; 8'h00 when out of range
// -----------------------------------------------------------------------------
module lcd_panel_model #(
  parameter int unsigned CMD_CYC  = 40,
  parameter int unsigned HOME_CYC = 1600
) (
  input  logic       CLK,
  input  logic       RESETN,
  input  logic       LCD_E,
  input  logic       LCD_RS,
  input  logic       LCD_RW,
  input  logic [7:0] LCD_DATA,
  output logic [7:0] DQ_OUT,
  output logic       DQ_OE,
  output logic       BUSY,
  output logic [6:0] AC,
  output logic       DISP_ON,
  output logic       CURSOR_ON,
  output logic       BLINK_ON,
  output logic       INC,
  output logic       TWO_LINE,
  output logic       OVERRUN,
  output logic       ADDR_ERR,
  input  logic [6:0] SCAN_ADDR,
  output logic [7:0] SCAN_CHAR
);

  localparam int unsigned DEPTH   = 80;
  localparam int unsigned CNT_MAX = (CMD_CYC > HOME_CYC) ? CMD_CYC : HOME_CYC;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

  // The wait counter is loaded with N-1 so BUSY is high for exactly N cycles.
  localparam logic [CNT_W-1:0] CMD_LOAD  = CNT_W'(CMD_CYC - 1);
  localparam logic [CNT_W-1:0] HOME_LOAD = CNT_W'(HOME_CYC - 1);
  localparam logic [6:0]       LAST_IDX  = 7'(DEPTH - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_WAIT
  } state_t;

  // ---------------------------------------------------------------------------
  // Address counter helpers: two 40-character lines at 0x00-0x27 and 0x40-0x67.
  // ---------------------------------------------------------------------------
  function automatic logic ac_legal(input logic [6:0] a);
    return (a <= 7'h27) || ((a >= 7'h40) && (a <= 7'h67));
  endfunction

  function automatic logic [6:0] ac_to_idx(input logic [6:0] a);
    return a[6] ? ({1'b0, a[5:0]} + 7'd40) : {1'b0, a[5:0]};
  endfunction

  function automatic logic [6:0] ac_step(input logic [6:0] a, input logic up);
    logic [6:0] r;
    if (up) begin
      if (a == 7'h27)      r = 7'h40;
      else if (a == 7'h67) r = 7'h00;
      else                 r = a + 7'd1;
    end else begin
      if (a == 7'h00)      r = 7'h67;
      else if (a == 7'h40) r = 7'h27;
      else                 r = a - 7'd1;
    end
    return r;
  endfunction

  // ---------------------------------------------------------------------------
  // Bus sampling: E goes through two flops; RS/RW/DATA travel alongside so they
  // stay aligned with the synchronized strobe.
  // ---------------------------------------------------------------------------
  logic       e_s1_q, e_s2_q, e_prev_q;
  logic       rs_s1_q, rs_s2_q, rw_s1_q, rw_s2_q;
  logic [7:0] data_s1_q, data_s2_q;
  // Bus value captured in the last cycle the synchronized E was high.
  logic       lat_rs_q, lat_rw_q;
  logic [7:0] lat_data_q;

  always_ff @(posedge CLK or posedge RESETN) begin
    if (RESETN) begin
      e_s1_q     <= 1'b0;
      e_s2_q     <= 1'b0;
      e_prev_q   <= 1'b0;
      rs_s1_q    <= 1'b0;
      rs_s2_q    <= 1'b0;
      rw_s1_q    <= 1'b0;
      rw_s2_q    <= 1'b0;
      data_s1_q  <= 8'h00;
      data_s2_q  <= 8'h00;
      lat_rs_q   <= 1'b0;
      lat_rw_q   <= 1'b0;
      lat_data_q <= 8'h00;
    end else begin
      // NOTE: sequential state always uses non-blocking assignments so every
      // flop samples the pre-edge value of its neighbours.
      e_s1_q    <= LCD_E;
      e_s2_q    <= e_s1_q;
      e_prev_q  <= e_s2_q;
      rs_s1_q   <= LCD_RS;
      rs_s2_q   <= rs_s1_q;
      rw_s1_q   <= LCD_RW;
      rw_s2_q   <= rw_s1_q;
      data_s1_q <= LCD_DATA;
      data_s2_q <= data_s1_q;
      if (e_s2_q) begin
        lat_rs_q   <= rs_s2_q;
        lat_rw_q   <= rw_s2_q;
        lat_data_q <= data_s2_q;
      end
    end
  end

  logic e_fall;
  assign e_fall = e_prev_q & ~e_s2_q;

  // ---------------------------------------------------------------------------
  // Panel state
  // ---------------------------------------------------------------------------
  state_t           state_q, state_d;
  logic [6:0]       fill_q, fill_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [6:0]       ac_q, ac_d;
  logic             inc_q, inc_d;
  logic             disp_q, disp_d;
  logic             cursor_q, cursor_d;
  logic             blink_q, blink_d;
  logic             two_line_q, two_line_d;
  logic             ovr_q, ovr_d;
  logic             aerr_q, aerr_d;
  logic [7:0]       dq_out_q, dq_out_d;
  logic [7:0]       scan_q, scan_d;

  logic [7:0]       ddram [DEPTH];
  logic             mem_we;
  logic [6:0]       mem_idx;
  logic [7:0]       mem_wdata;

  logic busy;
  assign busy = (state_q != ST_IDLE);

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    state_d    = state_q;
    fill_d     = fill_q;
    cnt_d      = cnt_q;
    ac_d       = ac_q;
    inc_d      = inc_q;
    disp_d     = disp_q;
    cursor_d   = cursor_q;
    blink_d    = blink_q;
    two_line_d = two_line_q;
    ovr_d      = ovr_q;
    aerr_d     = aerr_q;
    dq_out_d   = dq_out_q;
    mem_we     = 1'b0;
    mem_idx    = fill_q;
    mem_wdata  = 8'h20;

    // Read data is driven for as long as the host holds E high with RW=1.
    if (e_s2_q && rw_s2_q) begin
      if (!rs_s2_q)  dq_out_d = {busy, ac_q};
      else if (!busy) dq_out_d = ddram[ac_to_idx(ac_q)];
    end

    // Scan port: out-of-range indices read as zero.
    scan_d = (SCAN_ADDR <= LAST_IDX) ? ddram[SCAN_ADDR] : 8'h00;

    case (state_q)
      ST_CLEAR: begin
        mem_we    = 1'b1;
        mem_idx   = fill_q;
        mem_wdata = 8'h20;
        if (fill_q == LAST_IDX) begin
          state_d = ST_IDLE;
          fill_d  = 7'd0;
        end else begin
          fill_d = fill_q + 7'd1;
        end
      end
      ST_WAIT: begin
        if (cnt_q == '0) state_d = ST_IDLE;
        else             cnt_d   = cnt_q - 1'b1;
      end
      default: ;
    endcase

    // Transfers never collide with CLEAR writes: a non-status transfer is only
    // acted on when idle.
    if (e_fall) begin
      if (lat_rw_q && !lat_rs_q) begin
        // Status read: no side effects, allowed while busy.
      end else if (busy) begin
        ovr_d = 1'b1;
      end else if (lat_rw_q) begin
        // Data read: the byte was presented while E was high; step AC now.
        ac_d = ac_step(ac_q, inc_q);
      end else if (lat_rs_q) begin
        mem_we    = 1'b1;
        mem_idx   = ac_to_idx(ac_q);
        mem_wdata = lat_data_q;
        ac_d      = ac_step(ac_q, inc_q);
        state_d   = ST_WAIT;
        cnt_d     = CMD_LOAD;
      end else begin
        // Instruction: decoded by its highest set bit.
        if (lat_data_q[7]) begin
          if (ac_legal(lat_data_q[6:0])) ac_d   = lat_data_q[6:0];
          else                           aerr_d = 1'b1;
          state_d = ST_WAIT;
          cnt_d   = CMD_LOAD;
        end else if (lat_data_q[6]) begin
          // CGRAM is not modelled; only the busy time applies.
          state_d = ST_WAIT;
          cnt_d   = CMD_LOAD;
        end else if (lat_data_q[5]) begin
          two_line_d = lat_data_q[3];
          state_d    = ST_WAIT;
          cnt_d      = CMD_LOAD;
        end else if (lat_data_q[4]) begin
          // Cursor move changes AC; display shift leaves it alone.
          if (!lat_data_q[3]) ac_d = ac_step(ac_q, lat_data_q[2]);
          state_d = ST_WAIT;
          cnt_d   = CMD_LOAD;
        end else if (lat_data_q[3]) begin
          disp_d   = lat_data_q[2];
          cursor_d = lat_data_q[1];
          blink_d  = lat_data_q[0];
          state_d  = ST_WAIT;
          cnt_d    = CMD_LOAD;
        end else if (lat_data_q[2]) begin
          inc_d   = lat_data_q[1];
          state_d = ST_WAIT;
          cnt_d   = CMD_LOAD;
        end else if (lat_data_q[1]) begin
          ac_d    = 7'h00;
          state_d = ST_WAIT;
          cnt_d   = HOME_LOAD;
        end else if (lat_data_q[0]) begin
          ac_d    = 7'h00;
          inc_d   = 1'b1;
          state_d = ST_CLEAR;
          fill_d  = 7'd0;
        end
        // 8'h00 is a no-op and leaves the panel idle.
      end
    end
  end

  always_ff @(posedge CLK or posedge RESETN) begin
    if (RESETN) begin
      state_q    <= ST_CLEAR;
      fill_q     <= 7'd0;
      cnt_q      <= '0;
      ac_q       <= 7'h00;
      inc_q      <= 1'b1;
      disp_q     <= 1'b0;
      cursor_q   <= 1'b0;
      blink_q    <= 1'b0;
      two_line_q <= 1'b0;
      ovr_q      <= 1'b0;
      aerr_q     <= 1'b0;
      dq_out_q   <= 8'h00;
      scan_q     <= 8'h00;
    end else begin
      state_q    <= state_d;
      fill_q     <= fill_d;
      cnt_q      <= cnt_d;
      ac_q       <= ac_d;
      inc_q      <= inc_d;
      disp_q     <= disp_d;
      cursor_q   <= cursor_d;
      blink_q    <= blink_d;
      two_line_q <= two_line_d;
      ovr_q      <= ovr_d;
      aerr_q     <= aerr_d;
      dq_out_q   <= dq_out_d;
      scan_q     <= scan_d;
    end
  end

  // NOTE: the DDRAM array has no reset; the CLEAR sequence that follows every
  // reset fills it with spaces, so a reset branch would only cost logic.
  always_ff @(posedge CLK) begin
    if (mem_we) ddram[mem_idx] <= mem_wdata;
  end

  assign DQ_OUT    = dq_out_q;
  assign DQ_OE     = e_s2_q & rw_s2_q;
  assign BUSY      = busy;
  assign AC        = ac_q;
  assign DISP_ON   = disp_q;
  assign CURSOR_ON = cursor_q;
  assign BLINK_ON  = blink_q;
  assign INC       = inc_q;
  assign TWO_LINE  = two_line_q;
  assign OVERRUN   = ovr_q;
  assign ADDR_ERR  = aerr_q;
  assign SCAN_CHAR = scan_q;

endmodule

// File: tb/tb_lcd_panel_model.sv
// -----------------------------------------------------------------------------
// tb_lcd_panel_model
//
// Directed bench for lcd_panel_model: host transfers are driven on the falling
// clock edge and outputs are sampled on the falling edge. Expected values are
// hand-computed constants.
// -----------------------------------------------------------------------------
module tb_lcd_panel_model;

  localparam int unsigned CMD_CYC  = 40;
  localparam int unsigned HOME_CYC = 1600;

  logic       CLK = 1'b0;
  logic       RESETN = 1'b1;
  logic       LCD_E = 1'b0;
  logic       LCD_RS = 1'b0;
  logic       LCD_RW = 1'b0;
  logic [7:0] LCD_DATA = 8'h00;
  logic [7:0] DQ_OUT;
  logic       DQ_OE;
  logic       BUSY;
  logic [6:0] AC;
  logic       DISP_ON, CURSOR_ON, BLINK_ON, INC, TWO_LINE, OVERRUN, ADDR_ERR;
  logic [6:0] SCAN_ADDR = 7'd0;
  logic [7:0] SCAN_CHAR;

  int n_tests = 0;
  int n_fail  = 0;

  lcd_panel_model #(.CMD_CYC(CMD_CYC), .HOME_CYC(HOME_CYC)) dut (
    .CLK(CLK), .RESETN(RESETN), .LCD_E(LCD_E), .LCD_RS(LCD_RS),
    .LCD_RW(LCD_RW), .LCD_DATA(LCD_DATA), .DQ_OUT(DQ_OUT), .DQ_OE(DQ_OE),
    .BUSY(BUSY), .AC(AC), .DISP_ON(DISP_ON), .CURSOR_ON(CURSOR_ON),
    .BLINK_ON(BLINK_ON), .INC(INC), .TWO_LINE(TWO_LINE), .OVERRUN(OVERRUN),
    .ADDR_ERR(ADDR_ERR), .SCAN_ADDR(SCAN_ADDR), .SCAN_CHAR(SCAN_CHAR)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // One E pulse (two cycles high); returns once the transfer has been taken.
  task automatic xfer(input logic rs, input logic rw, input logic [7:0] d);
    @(negedge CLK);
    LCD_RS = rs; LCD_RW = rw; LCD_DATA = d; LCD_E = 1'b1;
    repeat (2) @(negedge CLK);
    LCD_E = 1'b0;
    repeat (4) @(negedge CLK);
  endtask

  // Counts consecutive falling-edge samples with BUSY high, starting now.
  task automatic measure_busy(output int n);
    n = 0;
    while (BUSY && n < 5000) begin
      n++;
      @(negedge CLK);
    end
  endtask

  // Write and measure how many cycles BUSY stays high afterwards.
  task automatic write_meas(input logic rs, input logic [7:0] d, input int exp, input string tag);
    int n;
    @(negedge CLK);
    LCD_RS = rs; LCD_RW = 1'b0; LCD_DATA = d; LCD_E = 1'b1;
    repeat (2) @(negedge CLK);
    LCD_E = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge CLK);
      if (BUSY) break;
    end
    measure_busy(n);
    check(tag, n, exp);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (BUSY && n < 5000) begin
      n++;
      @(negedge CLK);
    end
    if (BUSY) check("idle_timeout", 32'd1, 32'd0);
  endtask

  task automatic rd(input logic rs, output logic [7:0] dq, output logic oe);
    @(negedge CLK);
    LCD_RS = rs; LCD_RW = 1'b1; LCD_DATA = 8'h00; LCD_E = 1'b1;
    repeat (3) @(negedge CLK);
    dq = DQ_OUT;
    oe = DQ_OE;
    LCD_E = 1'b0;
    LCD_RW = 1'b0;
    repeat (4) @(negedge CLK);
  endtask

  task automatic scan(input logic [6:0] a, output logic [7:0] c);
    @(negedge CLK);
    SCAN_ADDR = a;
    @(negedge CLK);
    c = SCAN_CHAR;
  endtask

  task automatic scan_all_spaces(input string tag);
    int bad;
    logic [7:0] c;
    bad = 0;
    for (int i = 0; i < 80; i++) begin
      scan(7'(i), c);
      if (c !== 8'h20) bad++;
    end
    check(tag, bad, 0);
  endtask

  task automatic check_reset_outputs(input string pfx);
    check({pfx, "_ac"},    AC, 7'h00);
    check({pfx, "_inc"},   INC, 1'b1);
    check({pfx, "_dcb"},   {DISP_ON, CURSOR_ON, BLINK_ON}, 3'b000);
    check({pfx, "_n"},     TWO_LINE, 1'b0);
    check({pfx, "_flags"}, {OVERRUN, ADDR_ERR}, 2'b00);
    check({pfx, "_dq"},    {DQ_OE, DQ_OUT}, 9'h000);
    check({pfx, "_busy"},  BUSY, 1'b1);
    check({pfx, "_scan"},  SCAN_CHAR, 8'h00);
  endtask

  initial begin
    int n;
    logic [7:0] dq, c;
    logic oe;

    // Reset, power-up clear and first status read.
    repeat (3) @(negedge CLK);
    check_reset_outputs("rst");
    RESETN = 1'b0;
    #1;
    measure_busy(n);
    check("init_clear_busy", n, 80);
    rd(1'b0, dq, oe);
    check("init_status", dq, 8'h00);
    check("init_status_oe", oe, 1'b1);
    check("dq_oe_idle", DQ_OE, 1'b0);
    scan_all_spaces("init_scan");
    scan(7'd80, c);
    check("scan_oob", c, 8'h00);

    // Display on, two data writes.
    write_meas(1'b0, 8'h0C, CMD_CYC, "busy_0c");
    check("dcb_0c", {DISP_ON, CURSOR_ON, BLINK_ON}, 3'b100);
    write_meas(1'b1, 8'h41, CMD_CYC, "busy_d41");
    write_meas(1'b1, 8'h42, CMD_CYC, "busy_d42");
    scan(7'd0, c);  check("scan0_41", c, 8'h41);
    scan(7'd1, c);  check("scan1_42", c, 8'h42);
    check("ac_after_2", AC, 7'h02);

    // Data read from address 0 steps AC.
    xfer(1'b0, 1'b0, 8'h80); wait_idle();
    rd(1'b1, dq, oe);
    check("dread_val", dq, 8'h41);
    check("dread_ac", AC, 7'h01);
    check("dread_nobusy", BUSY, 1'b0);

    // Line-end wrap up and line-start wrap down.
    xfer(1'b0, 1'b0, 8'hA7); wait_idle();
    check("ac_27", AC, 7'h27);
    xfer(1'b1, 1'b0, 8'h5A); wait_idle();
    scan(7'd39, c); check("scan39_5a", c, 8'h5A);
    check("ac_wrap_40", AC, 7'h40);
    xfer(1'b0, 1'b0, 8'h04); wait_idle();
    check("inc_0", INC, 1'b0);
    xfer(1'b0, 1'b0, 8'h80); wait_idle();
    xfer(1'b1, 1'b0, 8'h33); wait_idle();
    check("ac_wrap_67", AC, 7'h67);
    scan(7'd0, c);  check("scan0_33", c, 8'h33);

    // Illegal address, then a write while busy.
    xfer(1'b0, 1'b0, 8'hA8);
    check("addr_err", ADDR_ERR, 1'b1);
    xfer(1'b1, 1'b0, 8'h77);
    check("overrun", OVERRUN, 1'b1);
    wait_idle();
    check("ac_unchanged", AC, 7'h67);
    scan(7'd79, c); check("scan79_kept", c, 8'h20);

    // Return home.
    write_meas(1'b0, 8'h02, HOME_CYC, "busy_home");
    check("home_ac", AC, 7'h00);
    rd(1'b0, dq, oe);
    check("home_status", dq, 8'h00);

    // Clear after a data write.
    xfer(1'b1, 1'b0, 8'h55); wait_idle();
    scan(7'd0, c);  check("scan0_55", c, 8'h55);
    write_meas(1'b0, 8'h01, 80, "busy_clear");
    check("clr_ac", AC, 7'h00);
    check("clr_inc", INC, 1'b1);
    scan_all_spaces("clr_scan");

    // Cursor moves with wrap, then a no-op.
    xfer(1'b0, 1'b0, 8'h14); wait_idle();
    check("shift_r", AC, 7'h01);
    xfer(1'b0, 1'b0, 8'h10); wait_idle();
    xfer(1'b0, 1'b0, 8'h10); wait_idle();
    check("shift_l_wrap", AC, 7'h67);
    xfer(1'b0, 1'b0, 8'h18); wait_idle();
    check("disp_shift_ac", AC, 7'h67);
    xfer(1'b0, 1'b0, 8'h00);
    check("noop_busy", BUSY, 1'b0);

    // Reset in the middle of a return-home wait.
    xfer(1'b0, 1'b0, 8'h0F); wait_idle();
    xfer(1'b0, 1'b0, 8'h28); wait_idle();
    check("flags_set", {DISP_ON, CURSOR_ON, BLINK_ON, TWO_LINE}, 4'b1111);
    xfer(1'b0, 1'b0, 8'h02);
    rd(1'b0, dq, oe);
    check("home_busy_status", dq, 8'h80);
    repeat (100) @(negedge CLK);
    RESETN = 1'b1;
    #1;
    check_reset_outputs("midrst");
    @(negedge CLK);
    RESETN = 1'b0;
    #1;
    measure_busy(n);
    check("midrst_clear_busy", n, 80);
    rd(1'b0, dq, oe);
    check("midrst_status", dq, 8'h00);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
